// File: rtl/data_bus_master.sv
// data_bus_master
// Single-request initiator for the Gumnut 8-bit data bus. A request taken in
// IDLE becomes one classic cyc/stb/we bus transaction. The transaction ends
// with a done pulse when the responder acks, or with an error pulse if no
// ack arrives within TIMEOUT bus cycles. A one-cycle RECOVER gap follows
// every transaction. The gap lets the responder's registered read-ack clear
// before the next strobe can sample it.
//
// Parameters:
//   TIMEOUT   max bus cycles to wait for ack; 0 = wait forever
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_i      asynchronous active-high reset
//   req_i      start request, sampled only while idle
//   req_we_i   1 = write, 0 = read
//   req_adr_i  transaction address
//   req_dat_i  write data
//   busy_o     high whenever a transaction (including recovery) is in progress
//   done_o     one-cycle pulse: transaction acked
//   err_o      one-cycle pulse: transaction timed out
//   rdata_o    read data, held until the next acked read
//   cyc_o      bus cycle
//   stb_o      bus strobe (mirrors cyc_o)
//   we_o       bus write enable
//   adr_o      bus address
//   dat_o      bus write data
//   ack_i      responder acknowledge
//   dat_i      responder read data
module data_bus_master #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       req_we_i,
    input  logic [7:0] req_adr_i,
    input  logic [7:0] req_dat_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] rdata_o,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic       ack_i,
    input  logic [7:0] dat_i
);

    // The counter must be able to hold TIMEOUT-1. It keeps at least one bit
    // so that the design still elaborates when the timeout is disabled.
    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_d, done_d, err_d, cyc_d, we_d;
    logic [7:0]    rdata_d, adr_d, dat_d;

    // Strobe and cycle are identical for single transfers. Driving stb_o from
    // the cyc_o register keeps it glitch-free without a second flop.
    assign stb_o = cyc_o;

    // State register and registered outputs. Reset drops the bus
    // immediately, so an aborted transaction never reports done or error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 8'h00;
            cyc_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= 8'h00;
            dat_o   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            err_o   <= err_d;
            rdata_o <= rdata_d;
            cyc_o   <= cyc_d;
            we_o    <= we_d;
            adr_o   <= adr_d;
            dat_o   <= dat_d;
        end
    end

    // Next-state and next-output logic. Bus fields keep their last values
    // by default. An ack is checked before the timeout, so an ack on the
    // final allowed cycle still counts as a successful transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_o;
        cyc_d   = cyc_o;
        we_d    = we_o;
        adr_d   = adr_o;
        dat_d   = dat_o;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_we_i ? req_dat_i : 8'h00;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_o) begin
                        rdata_d = dat_i;
                    end
                    state_d = RECOVER;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RECOVER;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOVER: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master
// Bench for data_bus_master (TIMEOUT = 4). A responder modelled on data_mem
// is included: writes ack combinationally, and reads ack one cycle late from
// a registered flag. That flag stays set one cycle after each read. A manual
// mode lets the bench drive ack/data directly. A transaction-level reference
// model predicts every output for every cycle. Directed sequences pin
// literal values at the interesting cycles.
module tb_data_bus_master;

    localparam int TO        = 4;
    localparam int MODE_MEM  = 0;
    localparam int MODE_NONE = 1;
    localparam int MODE_MAN  = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_i, req_we_i;
    logic [7:0] req_adr_i, req_dat_i;
    logic       busy_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [7:0] rdata_o, adr_o, dat_o;
    logic       ack_i;
    logic [7:0] dat_i;

    int total = 0;
    int bad   = 0;
    int mode  = MODE_MEM;
    bit chk_en = 1'b0;

    logic       ack_man = 1'b0;
    logic [7:0] dat_man = 8'h00;

    always #5 clk_i = ~clk_i;

    data_bus_master #(.TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .req_we_i  (req_we_i),
        .req_adr_i (req_adr_i),
        .req_dat_i (req_dat_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .ack_i     (ack_i),
        .dat_i     (dat_i)
    );

    // Responder: memory array with a registered read path and a read-ack
    // flag that lingers one cycle after the strobe drops.
    logic [7:0] mem [256];
    logic       rd_ack_q;
    logic [7:0] mem_rd;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ack_q <= 1'b0;
            mem_rd   <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            rd_ack_q <= (mode == MODE_MEM) && cyc_o && stb_o && !we_o;
            if (mode == MODE_MEM && cyc_o && stb_o) begin
                if (we_o) mem[adr_o] <= dat_o;
                else      mem_rd     <= mem[adr_o];
            end
        end
    end

    assign ack_i = (mode == MODE_MEM) ? ((cyc_o & stb_o & we_o) | rd_ack_q) :
                   (mode == MODE_MAN) ? ack_man : 1'b0;
    assign dat_i = (mode == MODE_MEM) ? mem_rd : dat_man;

    // Reference model: tracks the transaction in flight and the number of
    // bus cycles it has waited. The memory shadow holds what every acked
    // write should have stored.
    logic       e_busy, e_done, e_err, e_cyc, e_we;
    logic [7:0] e_adr, e_dat, e_rdata;
    logic [7:0] shadow [256];
    bit         m_inbus, m_recover;
    int         m_wait;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_busy <= 0; e_done <= 0; e_err <= 0; e_cyc <= 0; e_we <= 0;
            e_adr <= 0; e_dat <= 0; e_rdata <= 0;
            m_inbus <= 0; m_recover <= 0; m_wait <= 0;
            for (int i = 0; i < 256; i++) shadow[i] <= 8'h00;
        end else begin
            e_done <= 1'b0;
            e_err  <= 1'b0;
            if (m_recover) begin
                m_recover <= 1'b0;
                e_busy    <= 1'b0;
            end else if (m_inbus) begin
                m_wait <= m_wait + 1;
                if (ack_i) begin
                    e_done <= 1'b1; e_cyc <= 1'b0; m_inbus <= 1'b0; m_recover <= 1'b1;
                    if (!e_we)                  e_rdata <= (mode == MODE_MEM) ? shadow[e_adr] : dat_i;
                    else if (mode == MODE_MEM)  shadow[e_adr] <= e_dat;
                end else if (TO != 0 && m_wait + 1 == TO) begin
                    e_err <= 1'b1; e_cyc <= 1'b0; m_inbus <= 1'b0; m_recover <= 1'b1;
                end
            end else if (req_i) begin
                m_inbus <= 1'b1; m_wait <= 0; e_cyc <= 1'b1; e_busy <= 1'b1;
                e_we  <= req_we_i;
                e_adr <= req_adr_i;
                e_dat <= req_we_i ? req_dat_i : 8'h00;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; bus fields only while cyc is
    // expected high.
    always @(negedge clk_i) begin
        if (chk_en && !rst_i) begin
            checkOutput("m_busy",  busy_o,  e_busy);
            checkOutput("m_done",  done_o,  e_done);
            checkOutput("m_err",   err_o,   e_err);
            checkOutput("m_cyc",   cyc_o,   e_cyc);
            checkOutput("m_stb",   stb_o,   e_cyc);
            checkOutput("m_rdata", rdata_o, e_rdata);
            if (e_cyc) begin
                checkOutput("m_we",  we_o,  e_we);
                checkOutput("m_adr", adr_o, e_adr);
                checkOutput("m_dat", dat_o, e_dat);
            end
        end
    end

    // Presents one request at a negedge and removes it one cycle later. On
    // return the bench sits at the negedge of bus cycle 1.
    task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic doWrite(input logic [7:0] adr, input logic [7:0] dat);
        applyStimulus(1'b1, adr, dat);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_cnt;
        rst_i = 1'b1; req_i = 0; req_we_i = 0; req_adr_i = 0; req_dat_i = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_cyc", cyc_o, 0);
        checkOutput("rst_rdata", rdata_o, 0);
        checkOutput("rst_adr", adr_o, 0);
        chk_en = 1'b1;

        // Write 0x5A to 0x10, then read it back.
        applyStimulus(1'b1, 8'h10, 8'h5A);
        checkOutput("wr_c1_cyc", cyc_o, 1);
        checkOutput("wr_c1_we", we_o, 1);
        checkOutput("wr_c1_adr", adr_o, 8'h10);
        checkOutput("wr_c1_dat", dat_o, 8'h5A);
        @(negedge clk_i);
        checkOutput("wr_c2_done", done_o, 1);
        checkOutput("wr_c2_cyc", cyc_o, 0);
        checkOutput("wr_c2_busy", busy_o, 1);
        @(negedge clk_i);
        checkOutput("wr_c3_busy", busy_o, 0);
        applyStimulus(1'b0, 8'h10, 8'hEE);
        checkOutput("rd_c1_cyc", cyc_o, 1);
        checkOutput("rd_c1_dat", dat_o, 0);
        @(negedge clk_i);
        checkOutput("rd_c2_done", done_o, 0);
        @(negedge clk_i);
        checkOutput("rd_c3_done", done_o, 1);
        checkOutput("rd_c3_rdata", rdata_o, 8'h5A);
        checkOutput("rd_c3_model", e_rdata, 8'h5A);
        checkOutput("rd_c3_err", err_o, 0);
        @(negedge clk_i);
        checkOutput("rd_c4_busy", busy_o, 0);

        // Back-to-back reads with req held; the stale read-ack must not leak.
        doWrite(8'h20, 8'h11);
        doWrite(8'h21, 8'h22);
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 8'h20;
        @(negedge clk_i);
        req_adr_i = 8'h21;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("b2b_c3_rdata", rdata_o, 8'h11);
        checkOutput("b2b_c3_cyc", cyc_o, 0);
        @(negedge clk_i);
        checkOutput("b2b_c4_cyc", cyc_o, 0);
        @(negedge clk_i);
        req_i = 1'b0;
        checkOutput("b2b_c5_cyc", cyc_o, 1);
        checkOutput("b2b_c5_adr", adr_o, 8'h21);
        @(negedge clk_i);
        checkOutput("b2b_c6_rdata", rdata_o, 8'h11);
        @(negedge clk_i);
        checkOutput("b2b_c7_rdata", rdata_o, 8'h22);
        checkOutput("b2b_c7_model", e_rdata, 8'h22);
        @(negedge clk_i);

        // Timeout with ack never arriving.
        mode = MODE_NONE;
        applyStimulus(1'b0, 8'h30, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            checkOutput("to_cyc", cyc_o, 1);
            checkOutput("to_err", err_o, 0);
            @(negedge clk_i);
        end
        checkOutput("to_c5_err", err_o, 1);
        checkOutput("to_c5_cyc", cyc_o, 0);
        checkOutput("to_c5_rdata", rdata_o, 8'h22);
        @(negedge clk_i);
        checkOutput("to_c6_busy", busy_o, 0);

        // Ack on the last allowed cycle beats the timeout.
        mode = MODE_MAN;
        applyStimulus(1'b0, 8'h31, 8'h00);
        repeat (3) @(negedge clk_i);
        checkOutput("late_c4_cyc", cyc_o, 1);
        ack_man = 1'b1; dat_man = 8'hC3;
        @(negedge clk_i);
        ack_man = 1'b0;
        checkOutput("late_c5_done", done_o, 1);
        checkOutput("late_c5_err", err_o, 0);
        checkOutput("late_c5_rdata", rdata_o, 8'hC3);
        @(negedge clk_i);

        // Requests during BUS and RECOVER are dropped.
        mode = MODE_MEM;
        done_cnt = 0;
        applyStimulus(1'b0, 8'h20, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            done_cnt += int'(done_o);
            if (c == 2) begin req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 8'h40; end
            if (c == 4) begin
                req_i = 1'b0;
                checkOutput("ign_c4_busy", busy_o, 0);
            end
            @(negedge clk_i);
        end
        checkOutput("ign_done_count", 8'(done_cnt), 1);

        // Reset in the middle of a read.
        applyStimulus(1'b0, 8'h21, 8'h00);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("rstm_cyc", cyc_o, 0);
        checkOutput("rstm_stb", stb_o, 0);
        checkOutput("rstm_busy", busy_o, 0);
        checkOutput("rstm_rdata", rdata_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            checkOutput("rstm_done", done_o, 0);
            checkOutput("rstm_err", err_o, 0);
        end
        applyStimulus(1'b1, 8'h50, 8'h77);
        checkOutput("post_c1_cyc", cyc_o, 1);
        @(negedge clk_i);
        checkOutput("post_c2_done", done_o, 1);
        @(negedge clk_i);

        // Random traffic against the memory responder.
        for (int c = 0; c < 800; c++) begin
            req_i     = ($urandom_range(0, 1) == 1);
            req_we_i  = ($urandom_range(0, 1) == 1);
            req_adr_i = 8'($urandom_range(0, 15));
            req_dat_i = 8'($urandom);
            @(negedge clk_i);
        end
        req_i = 1'b0;
        repeat (8) @(negedge clk_i);

        // Random traffic with random ack timing, including timeouts.
        mode = MODE_MAN;
        for (int c = 0; c < 800; c++) begin
            req_i     = ($urandom_range(0, 2) == 0);
            req_we_i  = ($urandom_range(0, 1) == 1);
            req_adr_i = 8'($urandom);
            req_dat_i = 8'($urandom);
            ack_man   = ($urandom_range(0, 3) == 0);
            dat_man   = 8'($urandom);
            @(negedge clk_i);
        end
        req_i = 1'b0; ack_man = 1'b0;
        repeat (8) @(negedge clk_i);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
